// File: rtl/icache_set_assoc.sv
// N-way set-associative read-only instruction cache with first-invalid, then per-set round-robin replacement.
// Optional build macro ICACHE_WORD_SWAP_EN swaps the 32-bit halves of each fill beat (little-endian memory).
module icache_set_assoc #(
  parameter int BUS_DATA_WIDTH     = 64,
  parameter int BUS_TAG_WIDTH      = 13,
  parameter int WORD_SIZE          = 4,
  parameter int LOG_WORDS_PER_LINE = 4,
  parameter int ADDR_WIDTH         = 58,
  parameter int LOG_NUM_SETS       = 4,
  parameter int NUM_WAYS           = 2,
  parameter logic [BUS_TAG_WIDTH-1:0] REQ_TAG = 13'h1100
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic                          proc_req_i,
  input  logic [ADDR_WIDTH-1:0]         proc_line_addr_i,
  input  logic [LOG_WORDS_PER_LINE-1:0] proc_word_select_i,
  input  logic                          proc_flush_i,
  output logic                          proc_ack_o,
  output logic [8*WORD_SIZE-1:0]        proc_data_out_o,
  output logic                          bus_reqcyc_o,
  output logic [BUS_DATA_WIDTH-1:0]     bus_req_o,
  output logic [BUS_TAG_WIDTH-1:0]      bus_reqtag_o,
  input  logic                          bus_reqack_i,
  input  logic                          bus_respcyc_i,
  input  logic [BUS_DATA_WIDTH-1:0]     bus_resp_i,
  input  logic [BUS_TAG_WIDTH-1:0]      bus_resptag_i,
  output logic                          bus_respack_o
);
  localparam int WORD_BITS = 8 * WORD_SIZE;
  localparam int LINE_BITS = WORD_BITS << LOG_WORDS_PER_LINE;
  localparam int BEATS     = LINE_BITS / BUS_DATA_WIDTH;
  localparam int NUM_SETS  = 1 << LOG_NUM_SETS;
  localparam int TAG_W     = ADDR_WIDTH - LOG_NUM_SETS;
  localparam int OFF_BITS  = LOG_WORDS_PER_LINE + $clog2(WORD_SIZE);
  localparam int BA_W      = ADDR_WIDTH + OFF_BITS;
  localparam int WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WOFF_W    = LOG_WORDS_PER_LINE + $clog2(WORD_BITS);
  localparam int BOFF_W    = BEAT_W + $clog2(BUS_DATA_WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REQ, S_FILL, S_FLUSH} state_e;

  state_e                               state_q;
  logic [ADDR_WIDTH-1:0]                addr_q;
  logic [LOG_WORDS_PER_LINE-1:0]        word_q;
  logic                                 flush_pend_q;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]    valid_q;
  logic [NUM_SETS-1:0][WAY_W-1:0]       rr_q;
  logic [WAY_W-1:0]                     victim_q;
  logic                                 vic_valid_q;
  logic [BEAT_W-1:0]                    beat_q;
  logic                                 ack_q;
  logic [WORD_BITS-1:0]                 data_out_q;
  logic                                 reqcyc_q;
  logic [BUS_DATA_WIDTH-1:0]            req_q;
  logic [BUS_TAG_WIDTH-1:0]             reqtag_q;
  logic                                 respack_q;

  logic [LINE_BITS-1:0] data_mem [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]     tag_mem  [NUM_SETS][NUM_WAYS];

  logic [LOG_NUM_SETS-1:0]  idx;
  logic [TAG_W-1:0]         tag;
  logic                     hit, inv_found;
  logic [WAY_W-1:0]         hit_way, inv_way, victim_d;
  logic [LINE_BITS-1:0]     hit_line;
  logic [WORD_BITS-1:0]     hit_word;
  logic [WOFF_W-1:0]        word_off;
  logic [BOFF_W-1:0]        beat_off;
  logic [BUS_DATA_WIDTH-1:0] beat_data;
  logic [BUS_DATA_WIDTH-1:0] req_addr;
  logic [BA_W+BUS_DATA_WIDTH-1:0] req_wide;
  logic                     beat_acc, last_beat;

  assign idx = addr_q[LOG_NUM_SETS-1:0];
  assign tag = addr_q[ADDR_WIDTH-1:LOG_NUM_SETS];

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[idx][w] && tag_mem[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign victim_d = inv_found ? inv_way : rr_q[idx];
  assign hit_line = data_mem[idx][hit_way];
  assign word_off = {word_q, {$clog2(WORD_BITS){1'b0}}};
  assign hit_word = hit_line[word_off +: WORD_BITS];
  assign beat_off = {beat_q, {$clog2(BUS_DATA_WIDTH){1'b0}}};

  // Byte address is zero-extended through a wide temporary, then cut to bus width.
  assign req_wide = {{BUS_DATA_WIDTH{1'b0}}, addr_q, {OFF_BITS{1'b0}}};
  assign req_addr = req_wide[BUS_DATA_WIDTH-1:0];

`ifdef ICACHE_WORD_SWAP_EN
  for (genvar c = 0; c < BUS_DATA_WIDTH / 64; c++) begin : g_swap
    assign beat_data[c*64 +: 64] = {bus_resp_i[c*64 +: 32], bus_resp_i[c*64+32 +: 32]};
  end
`else
  assign beat_data = bus_resp_i;
`endif

  assign beat_acc  = (state_q == S_FILL) && bus_respcyc_i && (bus_resptag_i == REQ_TAG);
  assign last_beat = beat_acc && (beat_q == BEAT_W'(BEATS - 1));

  // Line storage carries no reset; only the valid bits decide residency.
  always_ff @(posedge clk_i) begin
    if (beat_acc) data_mem[idx][victim_q][beat_off +: BUS_DATA_WIDTH] <= beat_data;
    if (last_beat) tag_mem[idx][victim_q] <= tag;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      word_q       <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      rr_q         <= '0;
      victim_q     <= '0;
      vic_valid_q  <= 1'b0;
      beat_q       <= '0;
      ack_q        <= 1'b0;
      data_out_q   <= '0;
      reqcyc_q     <= 1'b0;
      req_q        <= '0;
      reqtag_q     <= '0;
      respack_q    <= 1'b0;
    end else begin
      ack_q     <= 1'b0;
      respack_q <= beat_acc;
      if (proc_flush_i && state_q != S_IDLE) flush_pend_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (proc_flush_i || flush_pend_q) begin
            flush_pend_q <= 1'b0;
            state_q      <= S_FLUSH;
          end else if (proc_req_i) begin
            addr_q  <= proc_line_addr_i;
            word_q  <= proc_word_select_i;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            data_out_q <= hit_word;
            ack_q      <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            victim_q    <= victim_d;
            vic_valid_q <= !inv_found;
            reqcyc_q    <= 1'b1;
            req_q       <= req_addr;
            reqtag_q    <= REQ_TAG;
            state_q     <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus_reqack_i) begin
            reqcyc_q <= 1'b0;
            req_q    <= '0;
            reqtag_q <= '0;
            beat_q   <= '0;
            state_q  <= S_FILL;
          end
        end
        S_FILL: begin
          if (last_beat) begin
            valid_q[idx][victim_q] <= 1'b1;
            if (vic_valid_q)
              rr_q[idx] <= (rr_q[idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_q[idx] + 1'b1;
            state_q <= S_LOOKUP;
          end else if (beat_acc) begin
            beat_q <= beat_q + 1'b1;
          end
        end
        S_FLUSH: begin
          valid_q <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign proc_ack_o      = ack_q;
  assign proc_data_out_o = data_out_q;
  assign bus_reqcyc_o    = reqcyc_q;
  assign bus_req_o       = req_q;
  assign bus_reqtag_o    = reqtag_q;
  assign bus_respack_o   = respack_q;
endmodule

// File: doc/icache_set_assoc.md
# icache_set_assoc

Parametrised N-way set-associative, read-only instruction cache; the successor to the direct-mapped instruction cache. It sits between the fetch stage and the system bus and serves 32-bit instruction words from resident lines. On a miss it fetches the whole line in bus-width beats into a victim way, chosen first-invalid and otherwise round-robin per set. Unlike the direct-mapped cache, it adds valid bits, a flush input, and configurable ways, sets and beat count.

## Interface
- BUS_DATA_WIDTH, 64, bus beat width; must divide LINE_BITS.
- BUS_TAG_WIDTH, 13, bus transaction tag width.
- WORD_SIZE, 4, bytes per instruction word (WORD_BITS = 8*WORD_SIZE).
- LOG_WORDS_PER_LINE, 4, log2 words per line (LINE_BITS = WORD_BITS << LOG_WORDS_PER_LINE).
- ADDR_WIDTH, 58, line address width (byte address minus offset bits).
- LOG_NUM_SETS, 4, index bits.
- NUM_WAYS, 2, associativity; legal values are 1, 2, 4.
- REQ_TAG, 13'h1100, tag driven on bus_reqtag and matched on bus_resptag.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous assert, active-low (0 = reset).
- proc_req  in  1  fetch request; held with address until proc_ack.
- proc_line_addr  in  ADDR_WIDTH  line address; tag = [ADDR_WIDTH-1:LOG_NUM_SETS], index = [LOG_NUM_SETS-1:0].
- proc_word_select  in  LOG_WORDS_PER_LINE  word within line.
- proc_flush  in  1  invalidate-all pulse.
- proc_ack  out  1  one-cycle pulse; data valid.
- proc_data_out  out  WORD_BITS  fetched word, registered.
- bus_reqcyc  out  1  line-read request valid.
- bus_req  out  BUS_DATA_WIDTH  byte address {line_addr, offset zeros}, zero-extended/truncated to width.
- bus_reqtag  out  BUS_TAG_WIDTH  REQ_TAG while requesting, else 0.
- bus_reqack  in  1  request accepted.
- bus_respcyc  in  1  response beat valid.
- bus_resp  in  BUS_DATA_WIDTH  beat data.
- bus_resptag  in  BUS_TAG_WIDTH  beat tag.
- bus_respack  out  1  beat acknowledge.

## Operation
- Storage: data[NUM_SETS][NUM_WAYS] of LINE_BITS; tag and valid per way; rr_ptr[NUM_SETS] of log2(NUM_WAYS) bits. Valid and rr_ptr are cleared by reset. Data and tag contents are don't-care after reset.
- States: IDLE, LOOKUP, REQ, FILL, FLUSH.
- IDLE:
  - proc_flush=1 -> FLUSH. Flush has priority over proc_req in the same cycle.
  - Otherwise proc_req=1 -> LOOKUP.
- LOOKUP: compares the tag against all ways of the indexed set.
  - Hit (valid && tag match): register the selected word into proc_data_out, pulse proc_ack, -> IDLE.
  - Miss: select victim = lowest-numbered invalid way, else rr_ptr[index]; -> REQ.
- REQ: bus_reqcyc=1, bus_req={line_addr, 0...}, bus_reqtag=REQ_TAG, all held. When bus_reqack=1 is sampled: drop bus_reqcyc, clear beat counter, -> FILL.
- FILL:
  - A beat is accepted when bus_respcyc && bus_resptag==REQ_TAG.
  - Beat k is written to victim bits [k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH], and bus_respack pulses the following cycle.
  - Non-matching beats are ignored and not acked.
  - After beat BEATS-1 (BEATS = LINE_BITS/BUS_DATA_WIDTH): write tag, set valid, advance rr_ptr[index] only if the victim was a valid way, -> LOOKUP. The guaranteed hit then acks.
- FLUSH: clears all valid bits in one cycle, -> IDLE.
- proc_flush outside IDLE is latched and taken on the next IDLE cycle, ahead of any pending proc_req.
- Bus responses in any state other than FILL are ignored, and bus_respack stays 0.

## Timing
- Reset values: all outputs 0; state IDLE; valid and rr_ptr all 0.
- Reset asserted mid-REQ or mid-FILL aborts immediately. A partial line is never marked valid.
- Hit latency: proc_req high at edge 0 gives proc_ack high after edge 2.
- Miss latency: 2 + reqack wait + BEATS accepted beats + 2 cycles.
- proc_ack is exactly one cycle. proc_data_out holds its value until the next ack.
- Beats may arrive back-to-back or with gaps; the counter advances only on accepted beats.
- All bus outputs are registered.

## Configuration
- ICACHE_WORD_SWAP_EN:
  - Defined: each beat's 32-bit halves are swapped before the write ({resp[31:0], resp[63:32]} per 64-bit chunk), for little-endian instruction memory. Requires BUS_DATA_WIDTH a multiple of 64.
  - Undefined: beats are written unmodified.

## Test plan
- Cold miss: set 3, line 0x40_0003, word 5, NUM_WAYS=2, beat k = 64'h(k)_(k+8) -> one bus request with bus_req=0x1000_00C0 and tag 0x1100, 8 respacks, ack with word 5 = beat 2's upper half (swap undefined).
- Re-fetch of the same line, word 0 -> ack 2 cycles after proc_req, no bus_reqcyc.
- Three distinct tags in set 1, then re-read the first -> the second fill goes to way 1, the third evicts way 0 (rr_ptr), and the first tag misses again.
- Non-matching tag beats interleaved during FILL -> no respack for them, line contents unaffected.
- proc_flush during FILL -> fill completes and acks, then all lines are invalid; the next fetch misses.
- Reset low after beat 3 of 8, then re-request the same line -> a full new bus request; stale beats are not acked.
